// File: rtl/rgb_pkg.sv
// -----------------------------------------------------------------------------
// rgb_pkg
// Shared definitions for the RGB frame path: converter word bit positions,
// FIFO entry header bytes, the frame controller state encoding and helpers
// that build pixel and end-of-frame marker entries.
// -----------------------------------------------------------------------------
package rgb_pkg;

    // Converter word bit positions
    localparam int VALID    = 31;
    localparam int SRESET   = 30;
    localparam int ERR      = 29;
    localparam int DATA_MSB = 23;

    // FIFO entry header bytes
    localparam logic [7:0] HDR_PIXEL  = 8'h80;
    localparam logic [7:0] HDR_MARKER = 8'hC0;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        IN_FRAME = 2'd1,
        DISCARD  = 2'd2
    } state_t;

    // Pixel entry: header byte followed by the 24-bit G-R-B payload
    function automatic logic [31:0] make_pixel(input logic [DATA_MSB:0] data);
        return {HDR_PIXEL, data};
    endfunction

    // Marker entry: header (error bit folded in), zero byte, frame pixel count
    function automatic logic [31:0] make_marker(input logic err, input logic [15:0] count);
        logic [31:0] m;
        m      = {HDR_MARKER, 8'h00, count};
        m[ERR] = err;
        return m;
    endfunction

endpackage

// File: rtl/rgb_sync_fifo.sv
// -----------------------------------------------------------------------------
// rgb_sync_fifo
// Single-clock first-word-fall-through FIFO, 2^DEPTH_LOG2 entries of WIDTH bits.
// Pointers carry one extra wrap bit so full and empty are distinguishable.
// Ports:
//   clk, rst          clock, asynchronous active-high reset
//   wr_en, wr_data    write request/data; ignored when full
//   rd_en             pop request; ignored when empty
//   rd_data           current head (zero while empty)
//   full, empty       occupancy flags (full is judged before any same-cycle pop)
// -----------------------------------------------------------------------------
module rgb_sync_fifo #(
    parameter int WIDTH      = 32,
    parameter int DEPTH_LOG2 = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    output logic [WIDTH-1:0] rd_data,
    output logic             full,
    output logic             empty
);

    localparam int DEPTH = 1 << DEPTH_LOG2;

    logic [WIDTH-1:0]    mem_r [DEPTH];
    logic [DEPTH_LOG2:0] wr_ptr_r;
    logic [DEPTH_LOG2:0] rd_ptr_r;
    logic                full_s;
    logic                empty_s;
    logic                wr_acc_s;
    logic                rd_acc_s;

    assign full_s   = (wr_ptr_r[DEPTH_LOG2] != rd_ptr_r[DEPTH_LOG2]) &&
                      (wr_ptr_r[DEPTH_LOG2-1:0] == rd_ptr_r[DEPTH_LOG2-1:0]);
    assign empty_s  = (wr_ptr_r == rd_ptr_r);
    assign wr_acc_s = wr_en && !full_s;
    assign rd_acc_s = rd_en && !empty_s;

    // Storage array; contents are don't-care until written, so no reset
    always_ff @(posedge clk) begin
        if (wr_acc_s) begin
            mem_r[wr_ptr_r[DEPTH_LOG2-1:0]] <= wr_data;
        end
    end

    // Read/write pointers, wrapping naturally through the extra MSB
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
        end else begin
            if (wr_acc_s) begin
                wr_ptr_r <= wr_ptr_r + {{DEPTH_LOG2{1'b0}}, 1'b1};
            end
            if (rd_acc_s) begin
                rd_ptr_r <= rd_ptr_r + {{DEPTH_LOG2{1'b0}}, 1'b1};
            end
        end
    end

    // Head is forced to zero while empty so stale entries never show
    assign rd_data = empty_s ? {WIDTH{1'b0}} : mem_r[rd_ptr_r[DEPTH_LOG2-1:0]];
    assign full    = full_s;
    assign empty   = empty_s;

endmodule

// File: rtl/rgb_frame_fifo_ctl.sv
// -----------------------------------------------------------------------------
// rgb_frame_fifo_ctl
// Frame controller between the serial-to-word converter and the RGB->RGBW
// stage. Detects one event per two-clock strobe, writes pixel entries into a
// FIFO, closes frames with a marker entry and drops pixels on overflow or
// over-length frames.
// Ports:
//   clk, rst      96 MHz clock, asynchronous active-high reset
//   in_word       converter word: [31] valid, [30] stream reset, [23:0] G-R-B
//   in_strobe     high for two clocks per word
//   out_word      FIFO head
//   out_valid     FIFO non-empty
//   out_ready     consumer pops head when out_valid & out_ready
//   pixel_count   pixels accepted in the current frame
//   frame_count   frames closed since reset (wraps)
//   overflow      sticky: an entry was dropped because the FIFO was full
//   too_long      sticky: a frame exceeded MAX_PIXELS
// -----------------------------------------------------------------------------
module rgb_frame_fifo_ctl
    import rgb_pkg::*;
#(
    parameter int DEPTH_LOG2 = 4,
    parameter int MAX_PIXELS = 256
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] in_word,
    input  logic        in_strobe,
    output logic [31:0] out_word,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [15:0] pixel_count,
    output logic [15:0] frame_count,
    output logic        overflow,
    output logic        too_long
);

    localparam logic [15:0] MAX_PC = 16'(MAX_PIXELS);

    logic              strobe_prev_r;
    logic              evt_r;
    logic              valid_r;
    logic              sreset_r;
    logic [DATA_MSB:0] data_r;
    logic              unused_bits_s;

    state_t            state_r;
    state_t            state_nx_s;
    logic [15:0]       pixel_count_r;
    logic [15:0]       pixel_count_nx_s;
    logic [15:0]       frame_count_r;
    logic [15:0]       frame_count_nx_s;
    logic              overflow_r;
    logic              overflow_nx_s;
    logic              too_long_r;
    logic              too_long_nx_s;

    logic              is_pixel_s;
    logic              is_sreset_s;
    logic              fifo_wr_s;
    logic [31:0]       fifo_wdata_s;
    logic              fifo_full_s;
    logic              fifo_empty_s;
    logic              strobe_rise_s;

    // Header bits between the flags and the payload carry no meaning here
    assign unused_bits_s = ^in_word[SRESET-1:DATA_MSB+1];

    assign strobe_rise_s = in_strobe && !strobe_prev_r;

    // Strobe edge detect and word capture. The previous-sample register resets
    // high so a strobe still asserted when reset releases is not an event.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            strobe_prev_r <= 1'b1;
            evt_r         <= 1'b0;
            valid_r       <= 1'b0;
            sreset_r      <= 1'b0;
            data_r        <= '0;
        end else begin
            strobe_prev_r <= in_strobe;
            evt_r         <= strobe_rise_s;
            if (strobe_rise_s) begin
                valid_r  <= in_word[VALID];
                sreset_r <= in_word[SRESET];
                data_r   <= in_word[DATA_MSB:0];
            end
        end
    end

    // Stream reset takes precedence over the valid flag
    assign is_sreset_s = evt_r && sreset_r;
    assign is_pixel_s  = evt_r && !sreset_r && valid_r;

    // Frame FSM: next state, FIFO write request and counter/flag updates
    always_comb begin
        state_nx_s       = state_r;
        pixel_count_nx_s = pixel_count_r;
        frame_count_nx_s = frame_count_r;
        overflow_nx_s    = overflow_r;
        too_long_nx_s    = too_long_r;
        fifo_wr_s        = 1'b0;
        fifo_wdata_s     = make_pixel(data_r);

        case (state_r)
            IDLE: begin
                if (is_pixel_s) begin
                    if (fifo_full_s) begin
                        overflow_nx_s = 1'b1;
                        state_nx_s    = DISCARD;
                    end else begin
                        fifo_wr_s        = 1'b1;
                        pixel_count_nx_s = 16'd1;
                        state_nx_s       = IN_FRAME;
                    end
                end else begin
                    state_nx_s = IDLE;
                end
            end
            IN_FRAME, DISCARD: begin
                if (is_sreset_s) begin
                    // Frame close: marker is lost if full, but the frame still counts
                    fifo_wdata_s     = make_marker(state_r == DISCARD, pixel_count_r);
                    fifo_wr_s        = !fifo_full_s;
                    overflow_nx_s    = overflow_r || fifo_full_s;
                    frame_count_nx_s = frame_count_r + 16'd1;
                    pixel_count_nx_s = 16'd0;
                    state_nx_s       = IDLE;
                end else if (is_pixel_s && (state_r == IN_FRAME)) begin
                    if (pixel_count_r == MAX_PC) begin
                        too_long_nx_s = 1'b1;
                        state_nx_s    = DISCARD;
                    end else if (fifo_full_s) begin
                        overflow_nx_s = 1'b1;
                        state_nx_s    = DISCARD;
                    end else begin
                        fifo_wr_s        = 1'b1;
                        pixel_count_nx_s = pixel_count_r + 16'd1;
                    end
                end else begin
                    state_nx_s = state_r;
                end
            end
            default: begin
                state_nx_s = IDLE;
            end
        endcase
    end

    // FSM state, counters and sticky flags
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r       <= IDLE;
            pixel_count_r <= 16'd0;
            frame_count_r <= 16'd0;
            overflow_r    <= 1'b0;
            too_long_r    <= 1'b0;
        end else begin
            state_r       <= state_nx_s;
            pixel_count_r <= pixel_count_nx_s;
            frame_count_r <= frame_count_nx_s;
            overflow_r    <= overflow_nx_s;
            too_long_r    <= too_long_nx_s;
        end
    end

    rgb_sync_fifo #(
        .WIDTH      (32),
        .DEPTH_LOG2 (DEPTH_LOG2)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (fifo_wr_s),
        .wr_data (fifo_wdata_s),
        .rd_en   (out_ready),
        .rd_data (out_word),
        .full    (fifo_full_s),
        .empty   (fifo_empty_s)
    );

    assign out_valid   = !fifo_empty_s;
    assign pixel_count = pixel_count_r;
    assign frame_count = frame_count_r;
    assign overflow    = overflow_r;
    assign too_long    = too_long_r;

endmodule

// File: tb/tb_rgb_frame_fifo_ctl.sv
// -----------------------------------------------------------------------------
// tb_rgb_frame_fifo_ctl
// Directed bench. dut: 4-entry FIFO, MAX_PIXELS=256. dut_m: 16-entry FIFO,
// MAX_PIXELS=4. Both share clock, reset and input stream.
// -----------------------------------------------------------------------------
module tb_rgb_frame_fifo_ctl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] in_word = 32'd0;
    logic        in_strobe = 1'b0;

    logic [31:0] out_word;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [15:0] pixel_count;
    logic [15:0] frame_count;
    logic        overflow;
    logic        too_long;

    logic [31:0] out_word_m;
    logic        out_valid_m;
    logic        out_ready_m = 1'b0;
    logic [15:0] pixel_count_m;
    logic [15:0] frame_count_m;
    logic        overflow_m;
    logic        too_long_m;

    int vectors = 0;
    int miscompares = 0;
    int pops;

    localparam logic [31:0] SRST = 32'h4000_0000;

    always #5 clk = ~clk;

    rgb_frame_fifo_ctl #(.DEPTH_LOG2(2), .MAX_PIXELS(256)) dut (
        .clk(clk), .rst(rst), .in_word(in_word), .in_strobe(in_strobe),
        .out_word(out_word), .out_valid(out_valid), .out_ready(out_ready),
        .pixel_count(pixel_count), .frame_count(frame_count),
        .overflow(overflow), .too_long(too_long)
    );

    rgb_frame_fifo_ctl #(.DEPTH_LOG2(4), .MAX_PIXELS(4)) dut_m (
        .clk(clk), .rst(rst), .in_word(in_word), .in_strobe(in_strobe),
        .out_word(out_word_m), .out_valid(out_valid_m), .out_ready(out_ready_m),
        .pixel_count(pixel_count_m), .frame_count(frame_count_m),
        .overflow(overflow_m), .too_long(too_long_m)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        in_strobe = 1'b0;
        out_ready = 1'b0;
        out_ready_m = 1'b0;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic send_word(input logic [31:0] w);
        @(negedge clk);
        in_word = w;
        in_strobe = 1'b1;
        repeat (2) @(negedge clk);
        in_strobe = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic pop_main(input string tag, input logic [31:0] exp);
        chk({tag, "_valid"}, {31'd0, out_valid}, 32'd1);
        chk(tag, out_word, exp);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    task automatic pop_m(input string tag, input logic [31:0] exp);
        chk({tag, "_valid"}, {31'd0, out_valid_m}, 32'd1);
        chk(tag, out_word_m, exp);
        out_ready_m = 1'b1;
        @(negedge clk);
        out_ready_m = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        // ---- reset state ----
        repeat (2) @(negedge clk);
        chk("rst_out_word", out_word, 32'd0);
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_pixel_count", {16'd0, pixel_count}, 32'd0);
        chk("rst_frame_count", {16'd0, frame_count}, 32'd0);
        chk("rst_flags", {30'd0, overflow, too_long}, 32'd0);
        chk("rst_m_out_valid", {31'd0, out_valid_m}, 32'd0);
        do_reset();

        // ---- basic frame of three pixels ----
        send_word(32'h8011_2233);
        chk("t1_pc1", {16'd0, pixel_count}, 32'd1);
        chk("t1_head_first", out_word, 32'h8011_2233);
        send_word(32'h8044_5566);
        send_word(32'h8077_8899);
        send_word(SRST);
        chk("t1_frame_count", {16'd0, frame_count}, 32'd1);
        chk("t1_pixel_count", {16'd0, pixel_count}, 32'd0);
        chk("t1_flags", {30'd0, overflow, too_long}, 32'd0);
        pop_main("t1_e0", 32'h8011_2233);
        pop_main("t1_e1", 32'h8044_5566);
        pop_main("t1_e2", 32'h8077_8899);
        pop_main("t1_marker", 32'hC000_0003);
        chk("t1_empty", {31'd0, out_valid}, 32'd0);

        // ---- idle-line stream resets and an ignored word ----
        do_reset();
        for (int i = 0; i < 5; i++) send_word(SRST);
        send_word(32'h0012_3456);
        chk("t2_empty", {31'd0, out_valid}, 32'd0);
        chk("t2_frame_count", {16'd0, frame_count}, 32'd0);
        chk("t2_pixel_count", {16'd0, pixel_count}, 32'd0);
        chk("t2_flags", {30'd0, overflow, too_long}, 32'd0);

        // ---- over-length frame on dut_m (MAX_PIXELS=4) ----
        do_reset();
        for (int i = 0; i < 6; i++) send_word(32'h8000_0010 + 32'(i));
        chk("t3_pc_frozen", {16'd0, pixel_count_m}, 32'd4);
        chk("t3_too_long", {31'd0, too_long_m}, 32'd1);
        send_word(SRST);
        chk("t3_overflow", {31'd0, overflow_m}, 32'd0);
        chk("t3_frame_count", {16'd0, frame_count_m}, 32'd1);
        chk("t3_pixel_count", {16'd0, pixel_count_m}, 32'd0);
        for (int i = 0; i < 4; i++) pop_m("t3_pix", 32'h8000_0010 + 32'(i));
        pop_m("t3_marker", 32'hE000_0004);
        chk("t3_empty", {31'd0, out_valid_m}, 32'd0);

        // ---- FIFO overflow on dut (4 entries), marker dropped ----
        do_reset();
        for (int i = 0; i < 5; i++) send_word(32'h80AB_0000 + 32'(i));
        send_word(SRST);
        chk("t4_overflow", {31'd0, overflow}, 32'd1);
        chk("t4_too_long", {31'd0, too_long}, 32'd0);
        chk("t4_frame_count", {16'd0, frame_count}, 32'd1);
        chk("t4_pixel_count", {16'd0, pixel_count}, 32'd0);
        chk("t4_head", out_word, 32'h80AB_0000);
        pops = 0;
        out_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            if (out_valid) pops++;
            @(negedge clk);
        end
        out_ready = 1'b0;
        chk("t4_pop_count", 32'(pops), 32'd4);
        chk("t4_empty", {31'd0, out_valid}, 32'd0);

        // ---- simultaneous write and pop with one entry ----
        do_reset();
        send_word(32'h80AA_AAAA);
        @(negedge clk);
        in_word = 32'h80BB_BBBB;
        in_strobe = 1'b1;
        @(negedge clk);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        in_strobe = 1'b0;
        chk("t5_valid", {31'd0, out_valid}, 32'd1);
        chk("t5_head", out_word, 32'h80BB_BBBB);
        chk("t5_pixel_count", {16'd0, pixel_count}, 32'd2);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        chk("t5_single_entry", {31'd0, out_valid}, 32'd0);

        // ---- async reset mid-frame with strobe held high ----
        do_reset();
        send_word(32'h8000_0001);
        send_word(32'h8000_0002);
        send_word(SRST);
        send_word(32'h8000_0003);
        send_word(32'h8000_0004);
        chk("t6_pre_frame_count", {16'd0, frame_count}, 32'd1);
        chk("t6_pre_overflow", {31'd0, overflow}, 32'd1);
        @(negedge clk);
        in_word = 32'h8000_0005;
        in_strobe = 1'b1;
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("t6_rst_out_word", out_word, 32'd0);
        chk("t6_rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("t6_rst_pixel_count", {16'd0, pixel_count}, 32'd0);
        chk("t6_rst_frame_count", {16'd0, frame_count}, 32'd0);
        chk("t6_rst_flags", {30'd0, overflow, too_long}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        chk("t6_held_strobe_valid", {31'd0, out_valid}, 32'd0);
        chk("t6_held_strobe_pc", {16'd0, pixel_count}, 32'd0);
        in_strobe = 1'b0;
        @(negedge clk);
        send_word(32'h8000_0006);
        chk("t6_new_pc", {16'd0, pixel_count}, 32'd1);
        chk("t6_new_head", out_word, 32'h8000_0006);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/rgb_frame_fifo_ctl.md
# rgb_frame_fifo_ctl

Frame-level controller placed directly after the serial-bit-to-word converter. It accepts each 32-bit pixel or stream-reset word, using the converter's two-clock strobe. It writes pixels into an internal FIFO and closes each frame with a marker entry. It drops pixels on overflow or over-length frames and presents the FIFO head to the downstream RGB→RGBW stage over a valid/ready handshake.

## Interface
- DEPTH_LOG2, 4: FIFO depth = 2^DEPTH_LOG2 entries of 32 bits.
- MAX_PIXELS, 256: max pixels accepted per frame; range 1..65535.
- clk  in  1  system clock, 96 MHz.
- rst  in  1  asynchronous, active-high reset; clears all state.
- in_word  in  32  converter word; [31] valid, [30] stream reset, [23:0] G-R-B.
- in_strobe  in  1  high for 2 clocks per word.
- out_word  out  32  FIFO head.
- out_valid  out  1  FIFO non-empty.
- out_ready  in  1  consumer pops head when out_valid & out_ready.
- pixel_count  out  16  pixels accepted in current frame.
- frame_count  out  16  frames closed since reset; wraps 0xFFFF→0.
- overflow  out  1  sticky: an entry was dropped because the FIFO was full.
- too_long  out  1  sticky: a frame exceeded MAX_PIXELS.

## Operation
- Reset values: out_word=0, out_valid=0, pixel_count=0, frame_count=0, overflow=0, too_long=0, state=IDLE, FIFO empty.
- Capture: one event per strobe. Event = in_strobe sampled 1 while the previous sample was 0; the word is registered on that edge. The second strobe clock is ignored.
- Event classes:
  - stream-reset event: in_word[30]=1.
  - pixel event: in_word[30]=0 and in_word[31]=1.
  - Words with [31]=0 and [30]=0 are ignored.
- Pixel entry: {8'h80, in_word[23:0]}.
- Marker entry: {8'hC0 | err<<5, 8'h00, pixel_count}, where err=1 if the frame entered DISCARD.
- State machine:
  - IDLE: pixel → write pixel entry, pixel_count=1, go IN_FRAME. Stream reset → no action (idle line). Stream resets repeat while the line is idle.
  - IN_FRAME: pixel with pixel_count<MAX_PIXELS and FIFO not full → write, pixel_count+1.
  - IN_FRAME: pixel with pixel_count==MAX_PIXELS → drop, too_long=1, go DISCARD.
  - IN_FRAME: pixel with FIFO full → drop, overflow=1, go DISCARD.
  - IN_FRAME: stream reset → write marker (err=0), frame_count+1, pixel_count=0, go IDLE.
  - DISCARD: pixels dropped; pixel_count frozen.
  - DISCARD: stream reset → write marker (err=1), frame_count+1, pixel_count=0, go IDLE.
- Marker with FIFO full: marker dropped, overflow=1. frame_count still increments and the state still goes to IDLE.
- Full is evaluated before the same-cycle pop. A write is rejected when full even if out_ready pops that cycle.
- Pointers are DEPTH_LOG2+1 bits. full = MSBs differ and lower bits equal; empty = pointers equal. They wrap naturally.
- Reset mid-frame or mid-strobe: everything clears immediately (async). A strobe still high after deassertion is not an event until it returns low and rises again.

## Timing
- Edge E0: first rising clk sampling in_strobe=1. The word is captured at E0 and the FIFO write occurs at E0+1. out_valid=1 and out_word valid after E0+1 when the FIFO was empty.
- A pop at edge P advances out_word after P. out_valid drops after P if that was the last entry.
- Simultaneous write and pop on a non-empty FIFO: the count is unchanged and both take effect.
- Sustained input rate: one event per ≥3 clocks. Converter spacing is far larger, about 120 clocks per bit.
- pixel_count, frame_count and the sticky flags update on the same edge as the corresponding write or drop decision (E0+1).

## Structure
- Shared package rgb_pkg:
  - Word bit-position constants: VALID=31, SRESET=30, ERR=29, DATA_MSB=23.
  - Marker/pixel header constants 8'h80 and 8'hC0.
  - State enum {IDLE, IN_FRAME, DISCARD}.
- Sub-module rgb_sync_fifo: parameterised single-clock FIFO with full/empty flags, async reset. The controller owns the FSM, counters and capture logic.

## Test plan
- Reset, then 3 pixels 0x112233, 0x445566, 0x778899, then a stream reset → FIFO holds 0x80112233, 0x80445566, 0x80778899, 0xC0000003. frame_count=1, pixel_count=0.
- Stream resets only, 5 of them, after reset → FIFO empty, frame_count=0, no flags.
- MAX_PIXELS=4, 6 pixels, then a stream reset → 4 pixel entries and marker 0xE0000004, too_long=1, overflow=0.
- DEPTH_LOG2=2, out_ready=0, 5 pixels, then a stream reset → 4 entries, overflow=1, marker dropped, frame_count=1. Raise out_ready → exactly 4 pops, then out_valid=0.
- Write and pop in the same cycle with 1 entry → out_valid stays 1 and out_word shows the new entry next.
- Assert rst mid-frame after 2 pixels with in_strobe held high → all outputs 0 immediately. After release, no event until in_strobe falls and rises again.
